// File: rtl/sum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator_pkg
// Description : Shared constants, the FSM state type and the result-width
//               helper for the sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_accumulator_pkg;

    // Width of one adder sum (0..510)
    localparam int SUM_W = 9;

    // IDLE: no samples held; ACCUM: 1..NUM_SAMPLES-1 samples held
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Smallest result width that holds num_samples worst-case sums exactly
    function automatic int min_acc_w(input int num_samples);
        return SUM_W + $clog2(num_samples);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_accumulator_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with count-based full/empty and a
//               same-cycle push+pop allowed when full. Head reads as zero
//               while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign w_rd    = rd_en && !empty;
    assign w_wr    = wr_en && (!full || w_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Accumulates NUM_SAMPLES adder sums per batch and queues each
//               batch total in a result FIFO; sticky overflow on drops.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACC_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             overflow
);

    localparam int                C_CNT_W = $clog2(NUM_SAMPLES);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(NUM_SAMPLES - 1);

    generate
        if (ACC_W < min_acc_w(NUM_SAMPLES)) begin : g_bad_acc_w
            $error("sum_accumulator: ACC_W too small for NUM_SAMPLES");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sum_accumulator: FIFO_DEPTH must be a power of two >= 2");
        end
        if (NUM_SAMPLES < 2 || NUM_SAMPLES > 64) begin : g_bad_samples
            $error("sum_accumulator: NUM_SAMPLES must be 2..64");
        end
    endgenerate

    state_t               r_state, w_state_nxt;
    logic [C_CNT_W-1:0]   r_count, w_count_nxt;
    logic [ACC_W-1:0]     r_acc,   w_acc_nxt;
    logic [ACC_W-1:0]     w_sum_ext;
    logic                 w_push;
    logic [ACC_W-1:0]     w_push_data;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 r_overflow;

    assign w_sum_ext = {{(ACC_W-SUM_W){1'b0}}, in_sum};
    assign busy      = (r_state == ACCUM);
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign overflow  = r_overflow;

    // State, sample count and running sum registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Next-state: clr restarts the batch (with the current sample if present);
    // the last sample pushes acc+in_sum and returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        w_push      = 1'b0;
        w_push_data = r_acc + w_sum_ext;
        if (clr) begin
            if (in_valid) begin
                w_state_nxt = ACCUM;
                w_count_nxt = C_CNT_W'(1);
                w_acc_nxt   = w_sum_ext;
            end else begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_acc_nxt   = '0;
            end
        end else if (in_valid) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ACCUM;
                    w_count_nxt = C_CNT_W'(1);
                    w_acc_nxt   = w_sum_ext;
                end
                ACCUM: begin
                    if (r_count == C_LAST) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                        w_acc_nxt   = '0;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                        w_acc_nxt   = r_acc + w_sum_ext;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_acc_nxt   = '0;
                end
            endcase
        end
    end

    // Sticky flag: a completed batch found the FIFO full with no pop to make room
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (w_push_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .empty   (w_empty),
        .full    (w_full)
    );

endmodule
`default_nettype wire
